spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  SPI mode-0 initiator. Turns a valid/ready register-write request into one
//  16-bit frame on ncs/sclk/copi: {rw, addr[6:0], data[7:0]}, MSB first.
//  Drives our oversampling SPI register peripheral (3-stage sync on every
//  input), so all timing is in clk cycles. Used as the on-chip/bench master
//  that programs output-enable, PWM-enable and duty-cycle registers 0x00-0x04.
// PARAMETERS
//  CLK_DIV     4  clk cycles per sclk half-period; >=3, elaboration error otherwise
//  CS_HOLD     4  clk cycles ncs stays low after the last sclk fall; >=3
//  GAP_CYCLES  4  clk cycles ncs stays high before the next frame; >=3
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  async active-low reset
//  req_valid   in   1  request present
//  req_ready   out  1  controller idle, accepts request this cycle
//  req_rw      in   1  1=write, 0=read
//  req_addr    in   7  register address
//  req_data    in   8  write data (sent for reads too)
//  busy        out  1  frame in progress (not IDLE)
//  done        out  1  1-cycle pulse, frame fully retired
//  sclk        out  1  SPI clock, idles low
//  ncs         out  1  chip select, active low, idles high
//  copi        out  1  controller-out data
//  cipo        in   1  peripheral-out data      (SPI_CTRL_READ_EN only)
//  rd_data     out  8  captured read data       (SPI_CTRL_READ_EN only)
//  rd_valid    out  1  1-cycle pulse with done on read frames (SPI_CTRL_READ_EN only)
// BEHAVIOUR
//  Reset: ncs=1, sclk=0, copi=0, busy=0, done=0, req_ready=1, rd_data=0,
//   rd_valid=0, state IDLE. Async assertion aborts any frame at once; the
//   peripheral sees <16 edges and discards it. Regs, not comb, drive pins.
//  Handshake: accept on req_valid&&req_ready; fields latched into 16b shift reg.
//   req_ready=1 only in IDLE; requests while busy are held off, never dropped.
//  FSM: IDLE -> LOW -> HIGH -> (LOW | HOLD) -> GAP -> IDLE.
//   Accept cycle: next edge ncs=0, sclk=0, copi=bit15, bit_cnt=0, enter LOW.
//   LOW : CLK_DIV cycles, sclk=0; on exit sclk<=1, enter HIGH.
//   HIGH: CLK_DIV cycles, sclk=1; on exit sclk<=0; if bit_cnt==15 enter HOLD,
//         else bit_cnt++, shift, copi<=next bit, enter LOW. copi only changes
//         at sclk fall, so it is stable for a full half-period around each rise.
//   HOLD: CS_HOLD cycles, sclk=0, ncs=0; on exit ncs<=1, copi<=0, enter GAP.
//   GAP : GAP_CYCLES cycles; last cycle done=1 (and rd_valid if read); -> IDLE.
//  Timing: ncs low exactly 32*CLK_DIV+CS_HOLD cycles; accept->done =
//   32*CLK_DIV+CS_HOLD+GAP_CYCLES cycles; exactly 16 sclk rises per frame.
//  Back-to-back: req_valid held high gives frames separated by GAP_CYCLES+1
//   cycles of ncs high (the extra one is the IDLE accept cycle).
//  Counters: div counter $clog2 of max(CLK_DIV,CS_HOLD,GAP_CYCLES)+1 bits,
//   reloaded per state; bit_cnt 4 bits, never wraps (exit at 15).
//  Reads are framed identically to writes; rw only affects capture.
// CONFIGURATION
//  SPI_CTRL_READ_EN defined: cipo passes a 2-flop synchroniser; synchronised
//   value is shifted into rd_shift on the last HIGH cycle of bits 8..15; for
//   rw=0 frames rd_data updates and rd_valid pulses with done; rd_data holds
//   otherwise. Not defined: cipo/rd_data/rd_valid ports and logic absent;
//   read frames are still transmitted in full.
// STRUCTURE
//  spi_pkg: FRAME_BITS=16, ADDR_W=7, DATA_W=8, state encoding, register
//   address constants (EN_OUT_LO=0x00 .. PWM_DUTY=0x04), min-timing constant 3.
//  Sub-module spi_ctrl_timer: loadable down-counter with zero flag shared by
//   LOW/HIGH/HOLD/GAP; FSM and shift reg stay in spi_controller.
// TESTING (bench pairs controller with the SPI register peripheral)
//  write rw=1 addr=0x00 data=0xF0 -> copi bits 1_0000000_11110000, 16 rises,
//   ncs low 132 cycles (defaults), done at 136; peripheral reg0=0xF0.
//  five back-to-back writes to 0x00-0x04 with req_valid held -> all regs
//   updated, ncs high exactly 5 cycles between frames, req_ready low while busy.
//  write addr=0x7F data=0xAA -> full 16-bit frame, done pulses, regs 0x00-0x04
//   unchanged.
//  rst_n low at bit 7 of a write to 0x04 -> ncs=1/sclk=0 same cycle; duty
//   stays 0x00; next request after release transfers normally.
//  CLK_DIV=3, CS_HOLD=3, GAP_CYCLES=3 -> write 0x02=0x55 lands; CLK_DIV=2 fails
//   elaboration.
//  SPI_CTRL_READ_EN: rw=0 addr=0x04 with model driving 0x3C on cipo bits 8-15
//   -> rd_data=0x3C, rd_valid coincident with done; write frame: no rd_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared frame geometry, FSM encoding, peripheral register map and timing limits
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int MIN_TIMING = 3;
  localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] PWM_EN_LO = 7'h02;
  localparam logic [ADDR_W-1:0] PWM_EN_HI = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY = 7'h04;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/spi_ctrl_timer.sv
// spi_ctrl_timer: loadable down-counter with zero flag, sized by the caller
module spi_ctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator sending {rw, addr, data} frames MSB first.
// Define SPI_CTRL_READ_EN to add cipo capture with rd_data/rd_valid.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_HOLD = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ncs,
  output logic              copi
`ifdef SPI_CTRL_READ_EN
  ,
  input  logic              cipo,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`endif
);
  generate
    if (CLK_DIV < MIN_TIMING || CS_HOLD < MIN_TIMING || GAP_CYCLES < MIN_TIMING) begin : g_bad_timing
      $error("spi_controller: CLK_DIV, CS_HOLD and GAP_CYCLES must each be >= 3");
    end
  endgenerate
  localparam int TW = $clog2(max3(CLK_DIV, CS_HOLD, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] DIV_LD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [FRAME_BITS-1:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic sclk_n, ncs_n, copi_n, load, zero;
  logic [TW-1:0] load_val;
  spi_ctrl_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    sclk_n = sclk;
    ncs_n = ncs;
    copi_n = copi;
    load = 1'b0;
    load_val = DIV_LD;
    unique case (state)
      IDLE: if (req_valid) begin
        state_n = LOW;
        shift_n = {req_rw, req_addr, req_data};
        bit_cnt_n = '0;
        ncs_n = 1'b0;
        sclk_n = 1'b0;
        copi_n = req_rw;
        load = 1'b1;
      end
      LOW: if (zero) begin
        state_n = HIGH;
        sclk_n = 1'b1;
        load = 1'b1;
      end
      HIGH: if (zero) begin
        sclk_n = 1'b0;
        load = 1'b1;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          state_n = HOLD;
          load_val = HOLD_LD;
        end else begin
          state_n = LOW;
          bit_cnt_n = bit_cnt + 1'b1;
          shift_n = shift << 1;
          copi_n = shift[FRAME_BITS-2];
        end
      end
      HOLD: if (zero) begin
        state_n = GAP;
        ncs_n = 1'b1;
        copi_n = 1'b0;
        load = 1'b1;
        load_val = GAP_LD;
      end
      GAP: if (zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      sclk <= 1'b0;
      ncs <= 1'b1;
      copi <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      sclk <= sclk_n;
      ncs <= ncs_n;
      copi <= copi_n;
    end
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == GAP && zero;
`ifdef SPI_CTRL_READ_EN
  logic [1:0] cipo_sync;
  logic [DATA_W-1:0] rd_shift;
  logic rw_q;
  // rd_data is loaded as ncs rises so it is already stable when done/rd_valid pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cipo_sync <= '0;
      rd_shift <= '0;
      rd_data <= '0;
      rw_q <= 1'b0;
    end else begin
      cipo_sync <= {cipo_sync[0], cipo};
      if (state == IDLE && req_valid) rw_q <= req_rw;
      if (state == HIGH && zero && bit_cnt[3]) rd_shift <= {rd_shift[DATA_W-2:0], cipo_sync[1]};
      if (state == HOLD && zero && !rw_q) rd_data <= rd_shift;
    end
  assign rd_valid = done && !rw_q;
`endif
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized register writes checked against a behavioural SPI peripheral model
`timescale 1ns/1ps
module tb_spi_controller;
  localparam int CD = 4, CH = 4, GP = 4;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_rw = 0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic req_ready, busy, done, sclk, ncs, copi;
  logic s_valid = 0, s_rw = 0;
  logic [6:0] s_addr = '0;
  logic [7:0] s_data = '0;
  logic s_ready, s_busy, s_done, s_sclk, s_ncs, s_copi;
`ifdef SPI_CTRL_READ_EN
  logic cipo = 0, s_cipo = 0;
  logic [7:0] rd_data, s_rd_data;
  logic rd_valid, s_rd_valid;
`endif
  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(CD), .CS_HOLD(CH), .GAP_CYCLES(GP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .busy(busy),
    .done(done), .sclk(sclk), .ncs(ncs), .copi(copi)
`ifdef SPI_CTRL_READ_EN
    , .cipo(cipo), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
  );

  spi_controller #(.CLK_DIV(3), .CS_HOLD(3), .GAP_CYCLES(3)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready),
    .req_rw(s_rw), .req_addr(s_addr), .req_data(s_data), .busy(s_busy),
    .done(s_done), .sclk(s_sclk), .ncs(s_ncs), .copi(s_copi)
`ifdef SPI_CTRL_READ_EN
    , .cipo(s_cipo), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
`endif
  );

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model: samples copi on sclk rise, commits only complete 16-bit writes to 0x00-0x04
  logic [7:0] per_regs [5];
  logic [7:0] exp_regs [5];
  logic [15:0] bits = '0, last_frame = '0;
  int rises = 0, last_rises = 0, low_run = 0, last_low = 0, high_run = 0, ready_viol = 0;
  int gaps[$];
  bit track_gaps = 0;
  initial foreach (per_regs[i]) begin per_regs[i] = '0; exp_regs[i] = '0; end
  always @(posedge sclk) if (!ncs) begin bits = {bits[14:0], copi}; rises++; end
  always @(negedge ncs) begin rises = 0; bits = '0; end
  always @(posedge ncs) begin
    last_frame = bits;
    last_rises = rises;
    if (rises == 16 && bits[15] && bits[14:8] <= 7'd4) per_regs[bits[10:8]] = bits[7:0];
  end
  always @(negedge clk) begin
    if (!ncs) begin
      if (high_run > 0) begin
        if (track_gaps) gaps.push_back(high_run);
        high_run = 0;
      end
      low_run++;
    end else begin
      if (low_run > 0) begin last_low = low_run; low_run = 0; end
      high_run++;
    end
    if (busy && req_ready) ready_viol++;
  end

  logic [15:0] s_bits = '0;
  int s_rises = 0, s_low = 0;
  always @(posedge s_sclk) if (!s_ncs) begin s_bits = {s_bits[14:0], s_copi}; s_rises++; end
  always @(negedge s_ncs) s_rises = 0;
  always @(negedge clk) if (!s_ncs) s_low++;

`ifdef SPI_CTRL_READ_EN
  logic [7:0] rd_byte = '0;
  int cidx = 0;
  function automatic logic cbit(input int i, input logic [7:0] b);
    return (i >= 8 && i < 16) ? b[15-i] : 1'b0;
  endfunction
  always @(negedge ncs) begin cidx = 0; cipo = cbit(0, rd_byte); end
  always @(negedge sclk) if (!ncs) begin cidx++; cipo = cbit(cidx, rd_byte); end
`endif

  function automatic void model_req(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    if (rw && addr <= 7'd4) exp_regs[addr[2:0]] = data;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), per_regs[i], exp_regs[i]);
  endtask

  task automatic wait_ready();
    int cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    if (!req_ready) check("ready_timeout", req_ready, 1);
  endtask

  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int lat;
    wait_ready();
    req_valid = 1; req_rw = rw; req_addr = addr; req_data = data;
    @(posedge clk); #1;
    req_valid = 0;
    check("busy_after_accept", {busy, req_ready}, 2'b10);
    model_req(rw, addr, data);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 2000);
    check("accept_to_done", lat, 32*CD + CH + GP);
`ifdef SPI_CTRL_READ_EN
    check("rd_valid_with_done", rd_valid, !rw);
    if (!rw) check("rd_data", rd_data, rd_byte);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("frame_bits", last_frame, {rw, addr, data});
    check("sclk_rises", last_rises, 16);
    check("ncs_low_cycles", last_low, 32*CD + CH);
  endtask

  initial begin
    int cyc, lat;
    logic [7:0] bd [5];
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lat;
    logic [7:0] bd [5];
    repeat (3) @(negedge clk);
    check("reset_pins", {ncs, sclk, copi, busy, done, req_ready}, 6'b100001);
`ifdef SPI_CTRL_READ_EN
    check("reset_rd", {rd_data, rd_valid}, 9'h000);
`endif
    rst_n = 1;

    send(1, 7'h00, 8'hF0);
    check_regs("w0");

    // abort a write to the duty register at bit 7
    wait_ready();
    req_valid = 1; req_rw = 1; req_addr = 7'h04; req_data = 8'hA5;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 0;
    while (rises < 8 && cyc < 1000) begin @(negedge clk); cyc++; end
    check("abort_reached_bit7", rises, 8);
    #2 rst_n = 0;
    #1 check("abort_pins", {ncs, sclk, busy}, 3'b100);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("abort_duty_kept", per_regs[4], exp_regs[4]);
    send(1, 7'h04, 8'h3C);
    check_regs("after_abort");

    // five back-to-back writes with req_valid held
    foreach (bd[i]) bd[i] = 8'($urandom);
    gaps.delete();
    track_gaps = 1;
    ready_viol = 0;
    wait_ready();
    req_valid = 1; req_rw = 1; req_addr = 7'h00; req_data = bd[0];
    for (int i = 0; i < 5; i++) begin
      cyc = 0;
      while (!req_ready && cyc < 1000) begin @(negedge clk); cyc++; end
      model_req(1, 7'(i), bd[i]);
      @(posedge clk); #1;
      if (i < 4) begin req_addr = 7'(i + 1); req_data = bd[i+1]; end
      else req_valid = 0;
    end
    cyc = 0;
    while (!done && cyc < 1000) begin @(negedge clk); cyc++; end
    @(negedge clk);
    @(negedge clk);
    track_gaps = 0;
    check("b2b_gap_count", gaps.size(), 5);
    for (int i = 1; i < gaps.size(); i++) check($sformatf("b2b_gap%0d", i), gaps[i], GP + 1);
    check("b2b_ready_while_busy", ready_viol, 0);
    check_regs("b2b");

    send(1, 7'h7F, 8'hAA);
    check_regs("addr7f");

`ifdef SPI_CTRL_READ_EN
    rd_byte = 8'h3C;
    send(0, 7'h04, 8'h00);
    check_regs("read04");
`endif

    for (int k = 0; k < 8; k++) begin
      logic rw;
      logic [6:0] a;
      rw = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 4));
`ifdef SPI_CTRL_READ_EN
      rd_byte = 8'($urandom);
`endif
      send(rw, a, 8'($urandom));
      check_regs($sformatf("rand%0d", k));
    end

    // minimum-timing instance
    s_low = 0;
    @(negedge clk);
    s_valid = 1; s_rw = 1; s_addr = 7'h02; s_data = 8'h55;
    @(posedge clk); #1;
    s_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_done && lat < 2000);
    check("fast_latency", lat, 32*3 + 3 + 3);
    check("fast_frame", s_bits, 16'h8255);
    check("fast_rises", s_rises, 16);
    check("fast_ncs_low", s_low, 32*3 + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
